// File: rtl/bist_pkg.sv
// Shared definitions for the BIST engine.
//   - state_t    : sequencer states
//   - cnt_w()    : width of a counter that must hold values 0..n
//   - default LFSR/MISR feedback tap masks for common widths
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHIFT,
        CAPTURE,
        FLUSH,
        COMPARE,
        DONE
    } state_t;

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Maximal-length feedback masks (bit i set = register bit i feeds the XOR).
    localparam logic [3:0]  LFSR_TAPS_4  = 4'b1100;
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

    localparam logic [7:0]  MISR_TAPS_8  = 8'hB8;
    localparam logic [15:0] MISR_TAPS_16 = 16'hB400;
    localparam logic [31:0] MISR_TAPS_32 = 32'h8020_0003;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register.
// Ports:
//   CLK  in        clock, rising edge
//   RST  in        synchronous active-high reset, clears the signature
//   clr  in        synchronous clear (start of a run)
//   en   in        absorb d into the signature this cycle
//   d    in  N_IN  parallel response bits, zero-extended to W
//   sig  out W     current signature
module bist_misr
    import bist_pkg::*;
#(
    parameter int           W    = 16,
    parameter logic [W-1:0] TAPS = MISR_TAPS_16,
    parameter int           N_IN = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            clr,
    input  logic            en,
    input  logic [N_IN-1:0] d,
    output logic [W-1:0]    sig
);

    logic [W-1:0] r_misr;
    logic [W-1:0] w_d_ext;
    logic [W-1:0] w_next;

    always_comb begin
        w_d_ext           = '0;
        w_d_ext[N_IN-1:0] = d;
        w_next            = {r_misr[W-2:0], ^(r_misr & TAPS)} ^ w_d_ext;
    end

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            r_misr <= '0;
        end else if (en) begin
            r_misr <= w_next;
        end
    end

    assign sig = r_misr;

endmodule

// File: rtl/bist_engine.sv
// Self-contained BIST engine: LFSR stimulus, shift/capture sequencing of a
// scan-inserted DUT, MISR response compaction and golden-signature compare.
// Ports:
//   CLK           in               clock, rising edge
//   RST           in               synchronous active-high reset
//   bist_start    in               start request (honoured in IDLE/DONE)
//   bist_abort    in               abort an active run (INIT..COMPARE)
//   func_in       in  N_FUNC_IN    mission-mode DUT inputs
//   dut_in        out N_FUNC_IN    DUT functional inputs (LFSR while running)
//   scan_en       out              DUT scan enable
//   scan_in       out              DUT scan chain input
//   resp          in  N_RESP       resp[0]=scan_out, upper bits=DUT outputs
//   bist_running  out              high in INIT..COMPARE
//   bist_end      out              high in DONE
//   pass_fail     out              1 = final signature matched GOLDEN
//   signature     out MISR_W       current MISR contents
module bist_engine
    import bist_pkg::*;
#(
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 8'h01,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_TAPS = 16'hB400,
    parameter int                SCAN_LEN  = 16,
    parameter int                N_PAT     = 256,
    parameter int                N_FUNC_IN = 3,
    parameter int                N_RESP    = 3,
    parameter logic [MISR_W-1:0] GOLDEN    = 16'h0000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 bist_start,
    input  logic                 bist_abort,
    input  logic [N_FUNC_IN-1:0] func_in,
    output logic [N_FUNC_IN-1:0] dut_in,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic [N_RESP-1:0]    resp,
    output logic                 bist_running,
    output logic                 bist_end,
    output logic                 pass_fail,
    output logic [MISR_W-1:0]    signature
);

    localparam int SHIFT_W = cnt_w(SCAN_LEN);
    localparam int PAT_W   = cnt_w(N_PAT);

    // An all-zero seed would lock the LFSR up, so it is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED_FIX =
        (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;
    localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(SCAN_LEN - 1);
    localparam logic [PAT_W-1:0]   PAT_LAST   = PAT_W'(N_PAT - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [LFSR_W-1:0]  r_lfsr;
    logic [SHIFT_W-1:0] r_shift_cnt;
    logic [PAT_W-1:0]   r_pat_cnt;
    logic               r_pass;

    logic               w_active;
    logic               w_abort;
    logic               w_shift_last;
    logic               w_pat_last;
    logic               w_misr_en;
    logic               w_misr_clr;
    logic [MISR_W-1:0]  w_sig;

    always_comb begin
        w_next_state = r_state;
        scan_en      = 1'b0;
        bist_running = 1'b0;
        bist_end     = 1'b0;
        w_misr_en    = 1'b0;
        w_misr_clr   = 1'b0;
        w_active     = (r_state != IDLE) && (r_state != DONE);
        w_abort      = bist_abort && w_active;
        w_shift_last = (r_shift_cnt == SHIFT_LAST);
        w_pat_last   = (r_pat_cnt == PAT_LAST);

        case (r_state)
            IDLE: begin
                if (bist_start) w_next_state = INIT;
            end
            INIT: begin
                bist_running = 1'b1;
                w_misr_clr   = 1'b1;
                w_next_state = SHIFT;
            end
            SHIFT: begin
                bist_running = 1'b1;
                scan_en      = 1'b1;
                w_misr_en    = 1'b1;
                if (w_shift_last) w_next_state = CAPTURE;
            end
            CAPTURE: begin
                bist_running = 1'b1;
                w_misr_en    = 1'b1;
                w_next_state = w_pat_last ? FLUSH : SHIFT;
            end
            FLUSH: begin
                bist_running = 1'b1;
                scan_en      = 1'b1;
                w_misr_en    = 1'b1;
                if (w_shift_last) w_next_state = COMPARE;
            end
            COMPARE: begin
                bist_running = 1'b1;
                w_next_state = DONE;
            end
            DONE: begin
                bist_end = 1'b1;
                if (bist_start) w_next_state = INIT;
            end
            default: w_next_state = IDLE;
        endcase

        // Abort drops scan_en in the abort cycle itself and freezes the
        // MISR so the partial signature can be inspected afterwards.
        if (w_abort) begin
            w_next_state = IDLE;
            scan_en      = 1'b0;
            w_misr_en    = 1'b0;
            w_misr_clr   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_lfsr      <= SEED_FIX;
            r_shift_cnt <= '0;
            r_pat_cnt   <= '0;
            r_pass      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_abort) begin
                r_pass <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (bist_start) r_pass <= 1'b0;
                    end
                    INIT: begin
                        r_lfsr      <= SEED_FIX;
                        r_shift_cnt <= '0;
                        r_pat_cnt   <= '0;
                    end
                    SHIFT, FLUSH: begin
                        r_lfsr      <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_TAPS)};
                        r_shift_cnt <= w_shift_last ? '0 : r_shift_cnt + 1'b1;
                    end
                    CAPTURE: begin
                        if (!w_pat_last) r_pat_cnt <= r_pat_cnt + 1'b1;
                    end
                    COMPARE: begin
                        r_pass <= (w_sig == GOLDEN);
                    end
                    default: ;
                endcase
            end
        end
    end

    bist_misr #(
        .W    (MISR_W),
        .TAPS (MISR_TAPS),
        .N_IN (N_RESP)
    ) u_misr (
        .CLK (CLK),
        .RST (RST),
        .clr (w_misr_clr),
        .en  (w_misr_en),
        .d   (resp),
        .sig (w_sig)
    );

    assign dut_in    = bist_running ? r_lfsr[N_FUNC_IN-1:0] : func_in;
    assign scan_in   = r_lfsr[LFSR_W-1];
    assign pass_fail = r_pass;
    assign signature = w_sig;

endmodule

// File: tb/tb_bist_engine.sv
module tb_bist_engine;

    localparam int          LW    = 4;
    localparam logic [3:0]  LT    = 4'b1100;
    localparam logic [3:0]  LS    = 4'b0001;
    localparam int          MW    = 16;
    localparam logic [15:0] MT    = 16'hB400;
    localparam int          SL    = 4;
    localparam int          NP    = 3;
    localparam int          NF    = 3;
    localparam int          NR    = 3;
    localparam int          NCYC  = NP * (SL + 1) + SL;
    localparam int          T_EXP = NP * (SL + 1) + SL + 2;

    // Reference scan DUT: 4-flop chain, scan_in enters bit 0, bit 3 is scan_out.
    function automatic logic [3:0] cap(input logic [3:0] s, input logic [2:0] d);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = s[(i + 1) % 4] ^ d[i % 3];
        return r;
    endfunction

    // Signature after n_cyc compaction cycles of a run, with resp[0] inverted
    // in compaction cycle flip_c (-1 = no fault).
    function automatic logic [15:0] model_sig(input int flip_c, input int n_cyc);
        logic [3:0]  lf;
        logic [3:0]  sc;
        logic [15:0] m;
        logic [2:0]  din;
        logic [2:0]  r;
        logic        shift;
        lf = LS;
        sc = 4'b0;
        m  = 16'b0;
        for (int c = 0; c < n_cyc; c++) begin
            shift = (c >= NP * (SL + 1)) || ((c % (SL + 1)) != SL);
            din   = lf[2:0];
            r     = {sc[1] & din[0], sc[0] ^ din[2], sc[3] ^ (c == flip_c)};
            m     = {m[14:0], ^(m & MT)} ^ {13'b0, r};
            if (shift) begin
                sc = {sc[2:0], lf[3]};
                lf = {lf[2:0], ^(lf & LT)};
            end else begin
                sc = cap(sc, din);
            end
        end
        return m;
    endfunction

    localparam logic [15:0] GOLD = model_sig(-1, NCYC);

    logic          CLK = 1'b0;
    logic          RST;
    logic          bist_start;
    logic          bist_abort;
    logic [NF-1:0] func_in;
    logic [NF-1:0] dut_in;
    logic          scan_en;
    logic          scan_in;
    logic [NR-1:0] resp;
    logic          bist_running;
    logic          bist_end;
    logic          pass_fail;
    logic [MW-1:0] signature;

    logic       dut_clr;
    logic       resp_flip;
    logic [3:0] sc;

    int vectors     = 0;
    int miscompares = 0;

    bist_engine #(
        .LFSR_W    (LW),
        .LFSR_TAPS (LT),
        .LFSR_SEED (LS),
        .MISR_W    (MW),
        .MISR_TAPS (MT),
        .SCAN_LEN  (SL),
        .N_PAT     (NP),
        .N_FUNC_IN (NF),
        .N_RESP    (NR),
        .GOLDEN    (GOLD)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .bist_start   (bist_start),
        .bist_abort   (bist_abort),
        .func_in      (func_in),
        .dut_in       (dut_in),
        .scan_en      (scan_en),
        .scan_in      (scan_in),
        .resp         (resp),
        .bist_running (bist_running),
        .bist_end     (bist_end),
        .pass_fail    (pass_fail),
        .signature    (signature)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (dut_clr)      sc <= 4'b0;
        else if (scan_en) sc <= {sc[2:0], scan_in};
        else              sc <= cap(sc, dut_in);
    end

    assign resp = {sc[1] & dut_in[0], sc[0] ^ dut_in[2], sc[3] ^ resp_flip};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_se(input int k);
        int c;
        if (k <= 1) return 1'b0;
        c = k - 2;
        if (c < NP * (SL + 1)) return ((c % (SL + 1)) != SL);
        if (c < NCYC) return 1'b1;
        return 1'b0;
    endfunction

    // Starts a run at the current negedge and follows it cycle by cycle.
    // flip_k / abort_k / rst_k select the observation cycle (k=1 is INIT) at
    // which a response fault, an abort or a reset is injected (0 = none).
    task automatic do_run(input int flip_k, input int abort_k, input int rst_k,
                          input bit noise, output int t_edges);
        logic [3:0] lf;
        logic [3:0] obs;
        logic [3:0] seq [4];
        int         adv;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1001;
        lf      = LS;
        adv     = 0;
        t_edges = -1;
        bist_start = 1'b1;
        dut_clr    = 1'b1;
        @(negedge CLK);
        bist_start = 1'b0;
        for (int k = 1; k <= T_EXP + 5; k++) begin
            if (bist_end) begin
                t_edges = k - 1;
                break;
            end
            check("running", bist_running, 1);
            check("scan_en", scan_en, exp_se(k));
            if (k == 1) check("pass_cleared", pass_fail, 0);
            if (exp_se(k)) begin
                obs = {scan_in, dut_in};
                check("lfsr", obs, lf);
                if (adv < 4) check("lfsr_seq", obs, seq[adv]);
                if (adv == 15) check("lfsr_period", obs, LS);
                else if (adv > 0) check("lfsr_no_early_repeat", obs != LS, 1);
                lf = {lf[2:0], ^(lf & LT)};
                adv++;
            end
            if (k == 2) dut_clr = 1'b0;
            resp_flip  = (k == flip_k);
            bist_start = noise && (k < T_EXP) && ($urandom_range(0, 1) == 1);
            if (k == abort_k) begin
                bist_abort = 1'b1;
                #1;
                check("abort_scan_en_now", scan_en, 0);
                @(negedge CLK);
                bist_abort = 1'b0;
                bist_start = 1'b0;
                check("abort_running", bist_running, 0);
                check("abort_end", bist_end, 0);
                check("abort_pass", pass_fail, 0);
                check("abort_scan_en", scan_en, 0);
                check("abort_sig_held", signature, model_sig(-1, k - 2));
                @(negedge CLK);
                check("abort_sig_still_held", signature, model_sig(-1, k - 2));
                t_edges = -2;
                break;
            end
            if (k == rst_k) begin
                RST = 1'b1;
                func_in = NF'($urandom);
                bist_start = 1'b0;
                @(negedge CLK);
                check("rst_running", bist_running, 0);
                check("rst_end", bist_end, 0);
                check("rst_pass", pass_fail, 0);
                check("rst_scan_en", scan_en, 0);
                check("rst_sig", signature, 0);
                check("rst_dut_in_mux", dut_in, func_in);
                RST = 1'b0;
                t_edges = -3;
                break;
            end
            @(negedge CLK);
        end
        bist_start = 1'b0;
        resp_flip  = 1'b0;
        dut_clr    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int fk;
        int ak;
        RST        = 1'b1;
        bist_start = 1'b0;
        bist_abort = 1'b0;
        func_in    = '0;
        dut_clr    = 1'b1;
        resp_flip  = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset state, with start/abort both asserted: reset must win.
        bist_start = 1'b1;
        bist_abort = 1'b1;
        func_in    = NF'($urandom);
        @(negedge CLK);
        check("reset_running", bist_running, 0);
        check("reset_end", bist_end, 0);
        check("reset_pass", pass_fail, 0);
        check("reset_scan_en", scan_en, 0);
        check("reset_sig", signature, 0);
        check("reset_dut_in_mux", dut_in, func_in);
        check("reset_scan_in", scan_in, LS[3]);
        RST        = 1'b0;
        bist_start = 1'b0;

        // Abort while idle has no effect; mux follows func_in.
        repeat (2) begin
            func_in = NF'($urandom);
            @(negedge CLK);
            check("idle_abort_running", bist_running, 0);
            check("idle_dut_in_mux", dut_in, func_in);
        end
        bist_abort = 1'b0;

        // Full run with random start requests while active (must be ignored).
        do_run(0, 0, 0, 1'b1, t);
        check("run1_latency", t, T_EXP);
        check("run1_sig", signature, GOLD);
        check("run1_pass", pass_fail, 1);

        // DONE holds; abort in DONE does nothing.
        bist_abort = 1'b1;
        repeat (2) begin
            func_in = NF'($urandom);
            @(negedge CLK);
            check("done_end", bist_end, 1);
            check("done_pass", pass_fail, 1);
            check("done_sig", signature, GOLD);
            check("done_dut_in_mux", dut_in, func_in);
        end
        bist_abort = 1'b0;

        // Restart straight from DONE.
        do_run(0, 0, 0, 1'b0, t);
        check("run2_latency", t, T_EXP);
        check("run2_sig", signature, GOLD);
        check("run2_pass", pass_fail, 1);

        // Single-bit response fault in one random compaction cycle.
        fk = $urandom_range(2, NCYC + 1);
        do_run(fk, 0, 0, 1'b0, t);
        check("flip_latency", t, T_EXP);
        check("flip_sig", signature, model_sig(fk - 2, NCYC));
        check("flip_sig_differs", signature != GOLD, 1);
        check("flip_pass", pass_fail, 0);

        // Abort somewhere in FLUSH, then a clean run.
        ak = $urandom_range(NP * (SL + 1) + 2, NCYC + 1);
        do_run(0, ak, 0, 1'b0, t);
        check("abort_path_taken", t, -2);
        do_run(0, 0, 0, 1'b0, t);
        check("run3_latency", t, T_EXP);
        check("run3_sig", signature, GOLD);
        check("run3_pass", pass_fail, 1);

        // Reset in the middle of SHIFT.
        do_run(0, 0, 4, 1'b0, t);
        check("rst_path_taken", t, -3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
